// File: rtl/pkt_seq_checker.sv
// AXI4-Stream skid-buffer register slice that classifies each packet's leading
// sequence number as in-order, gap or late and keeps saturating statistics.
module pkt_seq_checker #(
  parameter int C_DATA_WIDTH = 64,
  parameter int SEQ_OFFSET   = 32
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [C_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  output logic [C_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  input  logic                      stats_clr,
  output logic [31:0]               pkt_count,
  output logic [31:0]               in_order_count,
  output logic [31:0]               gap_count,
  output logic [31:0]               late_count,
  output logic [31:0]               expected_seq,
  output logic                      seq_error
);

  localparam int STRB_W = C_DATA_WIDTH / 8;

  typedef enum logic {HEAD = 1'b0, BODY = 1'b1} frame_e;

  logic                    s_ready_q, s_ready_d;
  logic                    m_valid_q, m_valid_d;
  logic [C_DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [STRB_W-1:0]       m_strb_q, m_strb_d;
  logic                    m_last_q, m_last_d;
  logic                    skid_valid_q, skid_valid_d;
  logic [C_DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic [STRB_W-1:0]       skid_strb_q, skid_strb_d;
  logic                    skid_last_q, skid_last_d;

  frame_e      state_q;
  logic        sync_q;
  logic [31:0] expected_q;
  logic [31:0] pkt_q, in_order_q, gap_q, late_q;
  logic        seq_error_q;

  logic        in_hs, out_free, head_hs, sync_eff, is_gap, is_late;
  logic [31:0] seq, diff;
  logic [31:0] pkt_base, in_order_base, gap_base, late_base;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign in_hs    = s_axis_tvalid & s_ready_q;
  assign out_free = ~m_valid_q | m_axis_tready;

  // The skid entry only fills while the output register is stalled, and it
  // always drains into the output register before new input is taken.
  always_comb begin
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_strb_d     = m_strb_q;
    m_last_d     = m_last_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_strb_d  = skid_strb_q;
    skid_last_d  = skid_last_q;
    if (out_free) begin
      if (skid_valid_q) begin
        m_valid_d    = 1'b1;
        m_data_d     = skid_data_q;
        m_strb_d     = skid_strb_q;
        m_last_d     = skid_last_q;
        skid_valid_d = 1'b0;
      end else begin
        m_valid_d = in_hs;
        if (in_hs) begin
          m_data_d = s_axis_tdata;
          m_strb_d = s_axis_tstrb;
          m_last_d = s_axis_tlast;
        end
      end
    end else if (in_hs) begin
      skid_valid_d = 1'b1;
      skid_data_d  = s_axis_tdata;
      skid_strb_d  = s_axis_tstrb;
      skid_last_d  = s_axis_tlast;
    end
    s_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s_ready_q    <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_strb_q     <= '0;
      m_last_q     <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_strb_q  <= '0;
      skid_last_q  <= 1'b0;
    end else begin
      s_ready_q    <= s_ready_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_strb_q     <= m_strb_d;
      m_last_q     <= m_last_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_strb_q  <= skid_strb_d;
      skid_last_q  <= skid_last_d;
    end
  end

  // A clear coinciding with a HEAD beat acts first, so that beat is seen unsynced.
  assign head_hs       = in_hs & (state_q == HEAD);
  assign seq           = s_axis_tdata[SEQ_OFFSET +: 32];
  assign diff          = seq - expected_q;
  assign sync_eff      = sync_q & ~stats_clr;
  assign is_gap        = sync_eff & ~diff[31] & (diff != 32'd0);
  assign is_late       = sync_eff & diff[31];
  assign pkt_base      = stats_clr ? 32'd0 : pkt_q;
  assign in_order_base = stats_clr ? 32'd0 : in_order_q;
  assign gap_base      = stats_clr ? 32'd0 : gap_q;
  assign late_base     = stats_clr ? 32'd0 : late_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= HEAD;
      sync_q      <= 1'b0;
      expected_q  <= '0;
      pkt_q       <= '0;
      in_order_q  <= '0;
      gap_q       <= '0;
      late_q      <= '0;
      seq_error_q <= 1'b0;
    end else begin
      if (in_hs) begin
        state_q <= s_axis_tlast ? HEAD : BODY;
      end
      seq_error_q <= head_hs & (is_gap | is_late);
      if (stats_clr) begin
        pkt_q      <= '0;
        in_order_q <= '0;
        gap_q      <= '0;
        late_q     <= '0;
        sync_q     <= 1'b0;
      end
      if (head_hs) begin
        pkt_q  <= sat_inc(pkt_base);
        sync_q <= 1'b1;
        if (is_gap) begin
          gap_q <= sat_inc(gap_base);
        end else if (is_late) begin
          late_q <= sat_inc(late_base);
        end else begin
          in_order_q <= sat_inc(in_order_base);
        end
        if (!is_late) begin
          expected_q <= seq + 32'd1;
        end
      end
    end
  end

  assign s_axis_tready  = s_ready_q;
  assign m_axis_tvalid  = m_valid_q;
  assign m_axis_tdata   = m_data_q;
  assign m_axis_tstrb   = m_strb_q;
  assign m_axis_tlast   = m_last_q;
  assign pkt_count      = pkt_q;
  assign in_order_count = in_order_q;
  assign gap_count      = gap_q;
  assign late_count     = late_q;
  assign expected_seq   = expected_q;
  assign seq_error      = seq_error_q;

endmodule

// File: tb/tb_pkt_seq_checker.sv
// Randomized bench for pkt_seq_checker: a transaction-level model (beat queue plus
// packet classifier) is compared against the DUT on every falling clock edge.
module tb_pkt_seq_checker;

  localparam int DW  = 64;
  localparam int SW  = DW / 8;
  localparam int OFF = 32;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [DW-1:0] s_axis_tdata;
  logic [SW-1:0] s_axis_tstrb;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic [SW-1:0] m_axis_tstrb;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          stats_clr;
  logic [31:0]   pkt_count, in_order_count, gap_count, late_count, expected_seq;
  logic          seq_error;

  int nChecks = 0;
  int nFails  = 0;
  bit randReady = 1'b0;

  // Reference model state
  logic [DW+SW:0] expQ[$];
  bit             mHead, mSync, mErr, readyGate;
  logic [31:0]    mExp, mPkt, mIn, mGap, mLate, mSeq;
  int             mDiff;
  int             errPulses;

  pkt_seq_checker #(.C_DATA_WIDTH(DW), .SEQ_OFFSET(OFF)) dut (
    .CLK(CLK), .RESET(RESET),
    .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .stats_clr(stats_clr), .pkt_count(pkt_count), .in_order_count(in_order_count),
    .gap_count(gap_count), .late_count(late_count), .expected_seq(expected_seq),
    .seq_error(seq_error)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] satInc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic checkOutput(input string name, input logic [79:0] actual, input logic [79:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare DUT against the model, then advance the model by the handshakes
  // that the coming rising edge will perform.
  always @(negedge CLK) begin
    if (RESET) begin
      checkOutput("rst_s_tready", 80'(s_axis_tready), 80'(0));
      checkOutput("rst_m_beat", 80'({m_axis_tvalid, m_axis_tlast, m_axis_tstrb, m_axis_tdata}), 80'(0));
      checkOutput("rst_counts", 80'({pkt_count, in_order_count} | {gap_count, late_count}), 80'(0));
      checkOutput("rst_exp_err", 80'({expected_seq, seq_error}), 80'(0));
      expQ.delete();
      mHead = 1'b1; mSync = 1'b0; mErr = 1'b0; readyGate = 1'b0;
      mExp = '0; mPkt = '0; mIn = '0; mGap = '0; mLate = '0;
      errPulses = 0;
    end else begin
      checkOutput("m_tvalid", 80'(m_axis_tvalid), 80'(expQ.size() != 0));
      if (m_axis_tvalid && expQ.size() != 0)
        checkOutput("m_beat", 80'({m_axis_tlast, m_axis_tstrb, m_axis_tdata}), 80'(expQ[0]));
      if (readyGate)
        checkOutput("s_tready", 80'(s_axis_tready), 80'(expQ.size() < 2));
      readyGate = 1'b1;
      checkOutput("pkt_count", 80'(pkt_count), 80'(mPkt));
      checkOutput("in_order_count", 80'(in_order_count), 80'(mIn));
      checkOutput("gap_count", 80'(gap_count), 80'(mGap));
      checkOutput("late_count", 80'(late_count), 80'(mLate));
      checkOutput("expected_seq", 80'(expected_seq), 80'(mExp));
      checkOutput("seq_error", 80'(seq_error), 80'(mErr));
      if (seq_error) errPulses++;
      mErr = 1'b0;
      if (m_axis_tvalid && m_axis_tready && expQ.size() != 0) void'(expQ.pop_front());
      if (stats_clr) begin
        mPkt = '0; mIn = '0; mGap = '0; mLate = '0; mSync = 1'b0;
      end
      if (s_axis_tvalid && s_axis_tready) begin
        expQ.push_back({s_axis_tlast, s_axis_tstrb, s_axis_tdata});
        if (mHead) begin
          mSeq  = s_axis_tdata[OFF +: 32];
          mDiff = mSeq - mExp;
          mPkt  = satInc(mPkt);
          if (!mSync || mDiff == 0) begin
            mIn = satInc(mIn); mExp = mSeq + 32'd1;
          end else if (mDiff > 0) begin
            mGap = satInc(mGap); mExp = mSeq + 32'd1; mErr = 1'b1;
          end else begin
            mLate = satInc(mLate); mErr = 1'b1;
          end
          mSync = 1'b1;
        end
        mHead = s_axis_tlast;
      end
    end
  end

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      m_axis_tready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic sendBeat(input logic [DW-1:0] data, input logic [SW-1:0] strb, input logic last, input logic clr);
    int waited;
    s_axis_tdata  = data;
    s_axis_tstrb  = strb;
    s_axis_tlast  = last;
    stats_clr     = clr;
    s_axis_tvalid = 1'b1;
    waited = 0;
    @(negedge CLK);
    while (!s_axis_tready && waited < 100) begin
      @(negedge CLK);
      waited++;
    end
    if (!s_axis_tready) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL handshake_timeout: s_axis_tready stayed 0, expected 1 within 100 cycles");
    end
    @(posedge CLK);
    #1;
    s_axis_tvalid = 1'b0;
    stats_clr     = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] seq, input int len, input bit clr, input bit idles);
    logic [DW-1:0] d;
    for (int b = 0; b < len; b++) begin
      if (idles && $urandom_range(0, 3) == 0) begin
        @(posedge CLK);
        #1;
      end
      d = {$urandom, $urandom};
      if (b == 0) d[OFF +: 32] = seq;
      sendBeat(d, SW'($urandom), b == len - 1, clr && b == 0);
    end
  endtask

  task automatic applyReset();
    @(posedge CLK);
    #1 RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    randReady = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    checkOutput("drained", 80'(m_axis_tvalid), 80'(0));
  endtask

  task automatic checkStats(input string tag, input logic [31:0] p, input logic [31:0] i, input logic [31:0] g,
                            input logic [31:0] l, input logic [31:0] e, input int pulses);
    checkOutput({tag, "_pkt"}, 80'(pkt_count), 80'(p));
    checkOutput({tag, "_inorder"}, 80'(in_order_count), 80'(i));
    checkOutput({tag, "_gap"}, 80'(gap_count), 80'(g));
    checkOutput({tag, "_late"}, 80'(late_count), 80'(l));
    checkOutput({tag, "_expseq"}, 80'(expected_seq), 80'(e));
    checkOutput({tag, "_errpulses"}, 80'(pulses), 80'(errPulses));
  endtask

  initial begin
    logic [31:0] nextSeq, seq;
    int r;
    RESET = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tstrb = '0; s_axis_tlast = 1'b0;
    stats_clr = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset_tready", 80'(s_axis_tready), 80'(0));
    checkOutput("reset_expseq", 80'(expected_seq), 80'(0));
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    checkOutput("tready_after_reset", 80'(s_axis_tready), 80'(1));

    $display("[TB] in-order 5,6,7");
    for (int k = 5; k <= 7; k++) applyStimulus(32'(k), 3, 1'b0, 1'b0);
    drain();
    checkStats("inorder", 3, 3, 0, 0, 8, 0);

    $display("[TB] gap and late 10,11,14,12");
    applyReset();
    applyStimulus(32'd10, 2, 1'b0, 1'b0);
    applyStimulus(32'd11, 2, 1'b0, 1'b0);
    applyStimulus(32'd14, 2, 1'b0, 1'b0);
    applyStimulus(32'd12, 2, 1'b0, 1'b0);
    drain();
    checkStats("gaplate", 4, 2, 1, 1, 15, 2);

    $display("[TB] wraparound");
    applyReset();
    applyStimulus(32'hFFFF_FFFE, 1, 1'b0, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 1, 1'b0, 1'b0);
    applyStimulus(32'h0000_0000, 1, 1'b0, 1'b0);
    drain();
    checkStats("wrap", 3, 3, 0, 0, 32'h1, 0);

    $display("[TB] stats_clr on head handshake");
    applyReset();
    for (int k = 1; k <= 4; k++) applyStimulus(32'(k), 2, 1'b0, 1'b0);
    drain();
    checkOutput("preclr_pkt", 80'(pkt_count), 80'(4));
    applyStimulus(32'd100, 3, 1'b1, 1'b0);
    drain();
    checkStats("clr", 1, 1, 0, 0, 101, 0);

    $display("[TB] random backpressure, 200 packets");
    applyReset();
    randReady = 1'b1;
    nextSeq = 32'd1000;
    for (int p = 0; p < 200; p++) begin
      r = $urandom_range(0, 9);
      if (r < 7) seq = nextSeq;
      else if (r < 9) seq = nextSeq + 32'($urandom_range(1, 5));
      else seq = nextSeq - 32'($urandom_range(1, 5));
      nextSeq = seq + 32'd1;
      applyStimulus(seq, $urandom_range(1, 6), 1'b0, 1'b1);
    end
    drain();
    checkOutput("random_pkt", 80'(pkt_count), 80'(200));
    checkOutput("random_sum", 80'(in_order_count + gap_count + late_count), 80'(200));

    $display("[TB] reset mid-packet");
    applyReset();
    begin
      logic [DW-1:0] d;
      d = {$urandom, $urandom};
      d[OFF +: 32] = 32'd3;
      sendBeat(d, SW'($urandom), 1'b0, 1'b0);
      sendBeat({$urandom, $urandom}, SW'($urandom), 1'b0, 1'b0);
    end
    #2 RESET = 1'b1;
    #1;
    checkOutput("midrst_tready", 80'(s_axis_tready), 80'(0));
    checkOutput("midrst_m_beat", 80'({m_axis_tvalid, m_axis_tlast, m_axis_tstrb, m_axis_tdata}), 80'(0));
    checkOutput("midrst_pkt", 80'(pkt_count), 80'(0));
    checkOutput("midrst_inorder", 80'(in_order_count), 80'(0));
    checkOutput("midrst_expseq", 80'(expected_seq), 80'(0));
    checkOutput("midrst_seqerr", 80'(seq_error), 80'(0));
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(posedge CLK);
    #1;
    applyStimulus(32'd7, 4, 1'b0, 1'b0);
    drain();
    checkStats("afterrst", 1, 1, 0, 0, 8, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #500000;
    nChecks++;
    nFails++;
    $display("[TB] FAIL watchdog: simulation time 500000 reached, expected completion earlier");
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/pkt_seq_checker.md
PKT_SEQ_CHECKER -- requirements
Module: pkt_seq_checker

Interface
REQ-001 The block SHALL have parameter C_DATA_WIDTH, default 64, giving the AXI4-Stream data width in bits.
REQ-002 The block SHALL have parameter SEQ_OFFSET, default 32, giving the LSB position of the 32-bit sequence field in the first beat; legal range 0..C_DATA_WIDTH-32.
REQ-003 The block SHALL have a single clock and an asynchronous, active-high reset, with these ports:
- CLK  in  1  sole clock; all logic on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  C_DATA_WIDTH  upstream data.
- s_axis_tstrb  in  C_DATA_WIDTH/8  byte strobes.
- s_axis_tvalid  in  1  upstream valid.
- s_axis_tready  out  1  ready to upstream.
- s_axis_tlast  in  1  last beat of packet.
- m_axis_tdata  out  C_DATA_WIDTH  downstream data.
- m_axis_tstrb  out  C_DATA_WIDTH/8  downstream strobes.
- m_axis_tvalid  out  1  downstream valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  downstream last.
- stats_clr  in  1  single-cycle synchronous clear of statistics.
- pkt_count  out  32  packets checked.
- in_order_count  out  32  packets with seq == expected.
- gap_count  out  32  packets with seq ahead of expected.
- late_count  out  32  packets with seq behind expected.
- expected_seq  out  32  next expected sequence number.
- seq_error  out  1  one-cycle pulse on gap or late classification.

Function
REQ-004 The datapath SHALL be a 2-entry skid-buffer register slice: tdata/tstrb/tlast pass unmodified, in order, no beat dropped or duplicated.
REQ-005 Latency SHALL be exactly 1 cycle from input handshake to m_axis_tvalid when the buffer is empty.
REQ-006 Sustained throughput SHALL be 1 beat/cycle while m_axis_tready=1.
REQ-007 s_axis_tready SHALL be driven from a register and SHALL deassert only when both skid entries are full.
REQ-008 m_axis_tvalid, once asserted, SHALL hold with stable data until m_axis_tready=1.
REQ-009 A 2-state FSM SHALL track framing: HEAD (next accepted beat is first of packet) and BODY.
REQ-010 FSM transitions: HEAD->BODY on accepted beat with tlast=0; BODY->HEAD on accepted beat with tlast=1; HEAD->HEAD on accepted beat with tlast=1 (single-beat packet).
REQ-011 On each accepted HEAD beat, seq = s_axis_tdata[SEQ_OFFSET+31:SEQ_OFFSET]; d = (seq - expected_seq) mod 2^32, interpreted as signed 32-bit.
REQ-012 An internal sync flag SHALL be cleared by reset or stats_clr; the first HEAD beat with sync=0 SHALL be classified in-order, set sync=1 and load expected_seq = seq+1.
REQ-013 With sync=1, classification SHALL be:
- d==0: in-order, expected_seq <= seq+1.
- d>0: gap, expected_seq <= seq+1.
- d<0: late, expected_seq unchanged.
REQ-014 Every classified packet SHALL increment pkt_count plus exactly one of in_order_count, gap_count or late_count, in the cycle after the HEAD handshake.
REQ-015 seq_error SHALL pulse high for exactly one cycle, one cycle after a gap or late HEAD handshake.
REQ-016 All counters SHALL saturate at 0xFFFFFFFF; expected_seq SHALL wrap modulo 2^32 (seq 0xFFFFFFFF in-order -> expected 0x00000000).
REQ-017 stats_clr SHALL zero the four counters and clear sync on the next edge.
REQ-018 If stats_clr coincides with a HEAD handshake, the clear SHALL take effect first and that packet SHALL then be classified as the first after sync, giving pkt_count=1 and in_order_count=1.
REQ-019 Backpressure SHALL NOT affect classification, which occurs at input handshake only.

Reset
REQ-020 While RESET=1, asynchronously: s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata/tstrb/tlast=0, all counters=0, expected_seq=0, seq_error=0, sync=0, FSM=HEAD.
REQ-021 s_axis_tready SHALL assert on the first rising edge after RESET deasserts.
REQ-022 Reset mid-packet SHALL discard skid contents; the next accepted beat after reset SHALL be treated as a HEAD beat.

Verification
REQ-023 Bench SHALL cover: seqs 5,6,7 (3-beat packets), tready=1 -> in_order_count=3, gap_count=0, late_count=0, expected_seq=8, seq_error never high, output equals input at 1-cycle latency.
REQ-024 Bench SHALL cover: seqs 10,11,14,12 -> in_order_count=2, gap_count=1, late_count=1, expected_seq=15, two seq_error pulses.
REQ-025 Bench SHALL cover: seqs 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 -> all in-order, expected_seq=0x00000001.
REQ-026 Bench SHALL cover: random m_axis_tready (50%), 200 random-length packets -> output stream bit-identical to input, s_axis_tready never low with a skid entry free.
REQ-027 Bench SHALL cover: stats_clr on the HEAD handshake of seq 100 after 4 prior packets -> pkt_count=1, in_order_count=1, expected_seq=101.
REQ-028 Bench SHALL cover: RESET asserted in BODY of a 4-beat packet -> all outputs zero immediately; the next packet with seq 7 is counted in-order with expected_seq=8.
